pe_act_broadcast: RTL and testbench

PE_ACT_BROADCAST -- requirements
Module: pe_act_broadcast

---
 rtl/pe_act_broadcast.sv | 120 ++++++++++++
 tb/tb_pe_act_broadcast.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_act_broadcast.sv
// rtl/pe_act_broadcast.sv - PE activation scanner/broadcaster; optional nz_cnt via PE_BCAST_STATS_EN
// Scans the local activation register file and emits {PE_IDX, addr, value} for nonzero values, then an all-zero terminator.
module pe_act_broadcast #(
   parameter int DATA_W = 16,
   parameter int LOCAL_W = 4,
   localparam int IDX_W = 6 + LOCAL_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [5:0]                PE_IDX,
   input  logic                      start_broadcast,
   input  logic [LOCAL_W:0]          act_no,
   input  logic                      act_regfile_dir,
   output logic                      rd_en,
   output logic                      rd_bank,
   output logic [LOCAL_W-1:0]        rd_addr,
   input  logic [DATA_W-1:0]         rd_data,
   output logic                      pkt_valid,
   input  logic                      pkt_ready,
   output logic [IDX_W+DATA_W-1:0]   pkt_data,
   output logic                      busy,
   output logic                      bcast_done
`ifdef PE_BCAST_STATS_EN
   ,
   output logic [LOCAL_W:0]          nz_cnt
`endif
);

   typedef enum logic [2:0] {IDLE, READ, EVAL, SEND, TERM} state_t;

   localparam logic [LOCAL_W:0] ACT_MAX = {1'b1, {LOCAL_W{1'b0}}};

   state_t           state;
   logic [LOCAL_W:0] addr;
   logic [LOCAL_W:0] act_cnt;
   logic [LOCAL_W:0] addr_nxt;
   logic             last;
   logic             step;

   // addr is one bit wider than rd_addr so a full scan of 2^LOCAL_W ends without wrap
   assign addr_nxt = addr + 1'b1;
   assign last     = (addr_nxt == act_cnt);
   assign step     = ((state == EVAL) && (rd_data == '0)) || ((state == SEND) && pkt_ready);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         addr       <= '0;
         act_cnt    <= '0;
         rd_en      <= 1'b0;
         rd_bank    <= 1'b0;
         rd_addr    <= '0;
         pkt_valid  <= 1'b0;
         pkt_data   <= '0;
         bcast_done <= 1'b0;
`ifdef PE_BCAST_STATS_EN
         nz_cnt     <= '0;
`endif
      end else begin
         bcast_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start_broadcast) begin
                  act_cnt <= (act_no > ACT_MAX) ? ACT_MAX : act_no;
                  rd_bank <= act_regfile_dir;
                  addr    <= '0;
                  rd_addr <= '0;
`ifdef PE_BCAST_STATS_EN
                  nz_cnt  <= '0;
`endif
                  if (act_no == '0) begin
                     state     <= TERM;
                     pkt_valid <= 1'b1;
                     pkt_data  <= '0;
                  end else begin
                     state <= READ;
                     rd_en <= 1'b1;
                  end
               end
            end
            READ: begin
               rd_en <= 1'b0;
               state <= EVAL;
            end
            EVAL: begin
               if (rd_data != '0) begin
                  pkt_data  <= {PE_IDX, addr[LOCAL_W-1:0], rd_data};
                  pkt_valid <= 1'b1;
                  state     <= SEND;
               end
            end
            SEND: begin
`ifdef PE_BCAST_STATS_EN
               if (pkt_ready) nz_cnt <= nz_cnt + 1'b1;
`endif
            end
            TERM: begin
               if (pkt_ready) begin
                  pkt_valid  <= 1'b0;
                  bcast_done <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // Shared advance after a zero value or an accepted data packet
         if (step) begin
            addr      <= addr_nxt;
            rd_addr   <= addr_nxt[LOCAL_W-1:0];
            pkt_data  <= '0;
            pkt_valid <= last;
            rd_en     <= !last;
            state     <= last ? TERM : READ;
         end
      end
   end

endmodule

// File: tb/tb_pe_act_broadcast.sv
// tb/tb_pe_act_broadcast.sv - scoreboard bench for pe_act_broadcast
module tb_pe_act_broadcast;
   localparam int DATA_W = 16;
   localparam int LOCAL_W = 4;
   localparam int PW = 6 + LOCAL_W + DATA_W;

   logic               clk;
   logic               rst_n;
   logic [5:0]         PE_IDX;
   logic               start_broadcast;
   logic [LOCAL_W:0]   act_no;
   logic               act_regfile_dir;
   logic               rd_en;
   logic               rd_bank;
   logic [LOCAL_W-1:0] rd_addr;
   logic [DATA_W-1:0]  rd_data;
   logic               pkt_valid;
   logic               pkt_ready;
   logic [PW-1:0]      pkt_data;
   logic               busy;
   logic               bcast_done;
`ifdef PE_BCAST_STATS_EN
   logic [LOCAL_W:0]   nz_cnt;
`endif

   pe_act_broadcast #(.DATA_W(DATA_W), .LOCAL_W(LOCAL_W)) dut (
      .clk(clk), .rst_n(rst_n), .PE_IDX(PE_IDX), .start_broadcast(start_broadcast),
      .act_no(act_no), .act_regfile_dir(act_regfile_dir), .rd_en(rd_en), .rd_bank(rd_bank),
      .rd_addr(rd_addr), .rd_data(rd_data), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
      .pkt_data(pkt_data), .busy(busy), .bcast_done(bcast_done)
`ifdef PE_BCAST_STATS_EN
      , .nz_cnt(nz_cnt)
`endif
   );

   int            tests;
   int            fails;
   logic [PW-1:0] exp_q[$];
   logic [15:0]   mem[2][16];
   int            rd_cnt;
   int            rd_base;
   int            done_cnt;
   logic          exp_bank;
   logic          ready_lvl;
   logic          ready_tog;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   // pkt_ready driver: level or alternating
   initial begin
      pkt_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1 pkt_ready = ready_tog ? ~pkt_ready : ready_lvl;
      end
   end

   // register-file model and read checker
   initial begin
      logic                en;
      logic                b;
      logic [LOCAL_W-1:0]  a;
      rd_data = 16'hBAD1;
      rd_cnt  = 0;
      forever begin
         @(negedge clk);
         en = rd_en; a = rd_addr; b = rd_bank;
         if (en) begin
            check("rd_bank", 32'(b), 32'(exp_bank));
            check("rd_addr", 32'(a), 32'(rd_cnt - rd_base));
            rd_cnt++;
         end
         @(posedge clk);
         #1 rd_data = en ? mem[b][a] : 16'hBAD1;
      end
   end

   // packet monitor
   initial begin
      logic          stall;
      logic [PW-1:0] prev;
      logic [PW-1:0] e;
      stall    = 1'b0;
      prev     = '0;
      done_cnt = 0;
      forever begin
         @(negedge clk);
         if (stall && rst_n) begin
            check("stall_valid", 32'(pkt_valid), 32'd1);
            check("stall_data", 32'(pkt_data), 32'(prev));
         end
         if (bcast_done) done_cnt++;
         if (pkt_valid && pkt_ready) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pkt: got %0h required none", pkt_data);
            end else begin
               e = exp_q.pop_front();
               check("pkt_data", 32'(pkt_data), 32'(e));
            end
         end
         stall = pkt_valid && !pkt_ready;
         prev  = pkt_data;
      end
   end

   task automatic start(input int n, input logic dir);
      @(posedge clk);
      #1;
      start_broadcast = 1'b1;
      act_no          = n[LOCAL_W:0];
      act_regfile_dir = dir;
      @(posedge clk);
      #1 start_broadcast = 1'b0;
   endtask

   task automatic wait_done(input string name, input int reads);
      int d0;
      d0 = done_cnt;
      for (int i = 0; i < 400 && done_cnt == d0; i++) @(negedge clk);
      check({name, "_done"}, 32'(done_cnt - d0), 32'd1);
      repeat (8) @(negedge clk);
      check({name, "_single_term"}, 32'(done_cnt - d0), 32'd1);
      check({name, "_q_empty"}, 32'(exp_q.size()), 32'd0);
      check({name, "_busy_idle"}, 32'(busy), 32'd0);
      check({name, "_reads"}, 32'(rd_cnt - rd_base), 32'(reads));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      tests = 0; fails = 0;
      rst_n = 1'b0; PE_IDX = 6'd3; start_broadcast = 1'b0; act_no = '0; act_regfile_dir = 1'b0;
      ready_lvl = 1'b1; ready_tog = 1'b0; exp_bank = 1'b0; rd_base = 0;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 16; i++) mem[b][i] = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_pkt_valid", 32'(pkt_valid), 32'd0);
      check("rst_pkt_data", 32'(pkt_data), 32'd0);
      check("rst_rd_en", 32'(rd_en), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_bcast_done", 32'(bcast_done), 32'd0);

      // T1: bank0 = [5,0,0,7], start in first cycle after reset release
      mem[0][0] = 16'd5; mem[0][3] = 16'd7;
      exp_q.push_back(26'h0300005);
      exp_q.push_back(26'h0330007);
      exp_q.push_back(26'h0);
      rst_n = 1'b1; start_broadcast = 1'b1; act_no = 5'd4;
      @(posedge clk);
      #1 start_broadcast = 1'b0;
      check("first_start_busy", 32'(busy), 32'd1);
      wait_done("t1", 4);
`ifdef PE_BCAST_STATS_EN
      check("t1_nz_cnt", 32'(nz_cnt), 32'd2);
`endif

      // T2: act_no = 0 -> terminator only, no reads
      rd_base = rd_cnt;
      exp_q.push_back(26'h0);
      start(0, 1'b0);
      wait_done("t2", 0);

      // T3: 16 nonzero values with alternating ready
      rd_base = rd_cnt;
      for (int i = 0; i < 16; i++) begin
         mem[0][i] = 16'h0100 + 16'(i);
         exp_q.push_back(26'h0300100 + 26'(i << 16) + 26'(i));
      end
      exp_q.push_back(26'h0);
      ready_tog = 1'b1;
      start(16, 1'b0);
      wait_done("t3", 16);
      ready_tog = 1'b0;
`ifdef PE_BCAST_STATS_EN
      check("t3_nz_cnt", 32'(nz_cnt), 32'd16);
`endif

      // T4: bank1 = [0,9,0], second start while busy must be ignored
      rd_base = rd_cnt;
      exp_bank = 1'b1;
      mem[1][0] = 16'd0; mem[1][1] = 16'd9; mem[1][2] = 16'd0;
      exp_q.push_back(26'h0310009);
      exp_q.push_back(26'h0);
      start(3, 1'b1);
      start(5, 1'b0);
      wait_done("t4", 3);

      // T5: reset while stalled in SEND, then a clean act_no=2 run
      exp_bank = 1'b0;
      rd_base = rd_cnt;
      mem[0][0] = 16'd5; mem[0][1] = 16'd0;
      ready_lvl = 1'b0;
      start(4, 1'b0);
      for (int i = 0; i < 20 && !pkt_valid; i++) @(negedge clk);
      check("t5_reached_send", 32'(pkt_valid), 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("t5_rst_valid", 32'(pkt_valid), 32'd0);
      check("t5_rst_data", 32'(pkt_data), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_rd_en", 32'(rd_en), 32'd0);
      begin
         int d0;
         d0 = done_cnt;
         repeat (3) @(negedge clk);
         check("t5_no_term_on_reset", 32'(done_cnt - d0), 32'd0);
      end
      ready_lvl = 1'b1;
      @(posedge clk);
      #1 rst_n = 1'b1;
      rd_base = rd_cnt;
      exp_q.push_back(26'h0300005);
      exp_q.push_back(26'h0);
      start(2, 1'b0);
      wait_done("t5", 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
